// File: rtl/instruction_fetch_unit.sv
// Schwap instruction fetch unit: owns PC, IR and NIR, and issues handshaked
// one- or two-word instruction reads on behalf of the control FSM.
module instruction_fetch_unit #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_write,
  input  logic              pc_src,
  input  logic              ir_write,
  input  logic              next_inst_write,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read_req,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] next_inst,
  output logic [3:0]        opcode,
  output logic              fetch_busy,
  output logic              seq_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ_IR  = 2'd1,
    REQ_NIR = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic two_word;
  logic start_fetch;
  logic load_ir;
  logic load_nir;
  logic pc_update;
  logic strobe_err;

  // ---------------------------------------------------------------------
  // Next-state and strobe decode
  // ---------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_nxt   = state;
    start_fetch = 1'b0;
    load_ir     = 1'b0;
    load_nir    = 1'b0;
    pc_update   = 1'b0;
    strobe_err  = 1'b0;

    case (state)
      IDLE: begin
        pc_update = pc_write;
        if (ir_write) begin
          start_fetch = 1'b1;
          state_nxt   = REQ_IR;
        end
      end
      REQ_IR: begin
        strobe_err = pc_write | ir_write;
        if (mem_rvalid) begin
          load_ir   = 1'b1;
          state_nxt = two_word ? REQ_NIR : IDLE;
        end
      end
      REQ_NIR: begin
        strobe_err = pc_write | ir_write;
        if (mem_rvalid) begin
          load_nir  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------
  // PC, IR, NIR and address registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      ir        <= '0;
      next_inst <= '0;
      mem_addr  <= '0;
      two_word  <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      // The fetch captures the pre-edge PC, so a same-edge PC update is safe.
      if (start_fetch) begin
        mem_addr <= pc;
        two_word <= next_inst_write;
      end
      if (pc_update) begin
        pc <= pc_src ? pc + ADDR_W'(1) : alu_result;
      end
      // NIR word follows the fetched instruction, wrapping at the top of memory.
      if (load_ir) begin
        ir <= mem_rdata;
        if (two_word) mem_addr <= mem_addr + ADDR_W'(1);
      end
      if (load_nir) begin
        next_inst <= mem_rdata;
      end
      if (strobe_err) begin
        seq_err <= 1'b1;
      end
    end
  end

  // Request and busy come straight from the state flop: no input-to-output path.
  assign mem_read_req = (state != IDLE);
  assign fetch_busy   = (state != IDLE);
  assign opcode       = ir[DATA_W-1 -: 4];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: PC vector table, directed
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write, pc_src, ir_write, next_inst_write;
  logic [15:0] alu_result;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic [15:0] mem_addr;
  logic        mem_read_req;
  logic [15:0] pc;
  logic [15:0] ir;
  logic [15:0] next_inst;
  logic [3:0]  opcode;
  logic        fetch_busy;
  logic        seq_err;

  instruction_fetch_unit #(.DATA_W(16), .ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_write        (pc_write),
    .pc_src          (pc_src),
    .ir_write        (ir_write),
    .next_inst_write (next_inst_write),
    .alu_result      (alu_result),
    .mem_rdata       (mem_rdata),
    .mem_rvalid      (mem_rvalid),
    .mem_addr        (mem_addr),
    .mem_read_req    (mem_read_req),
    .pc              (pc),
    .ir              (ir),
    .next_inst       (next_inst),
    .opcode          (opcode),
    .fetch_busy      (fetch_busy),
    .seq_err         (seq_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Memory image and responder state
  logic [15:0] mem_img [0:65535];
  int          mem_lat  = 0;
  int          wcnt     = 0;
  bit          rand_lat = 1'b0;

  // Reference model: pending word reads in issue order
  typedef struct {
    logic [15:0] addr;
    bit          to_nir;
  } fetch_t;
  fetch_t      q[$];
  logic [15:0] m_pc, m_ir, m_nir;
  bit          m_err;

  typedef struct {
    logic        pw;
    logic        ps;
    logic [15:0] alu;
    logic        niw;
    logic [15:0] exp_pc;
  } pc_vec_t;
  pc_vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc  = 16'h0000;
    m_ir  = 16'h0000;
    m_nir = 16'h0000;
    m_err = 1'b0;
  endtask

  task automatic compare_all();
    check("pc",           pc,           m_pc);
    check("ir",           ir,           m_ir);
    check("next_inst",    next_inst,    m_nir);
    check("opcode",       opcode,       m_ir[15:12]);
    check("fetch_busy",   fetch_busy,   q.size() != 0);
    check("mem_read_req", mem_read_req, q.size() != 0);
    check("seq_err",      seq_err,      m_err);
    if (q.size() != 0) check("mem_addr", mem_addr, q[0].addr);
  endtask

  // One clock: drive inputs at the falling edge, advance the model across the
  // rising edge, then compare at the next falling edge.
  task automatic step(input logic pw, input logic ps, input logic [15:0] alu,
                      input logic iw, input logic niw,
                      input logic spur, input logic [15:0] spur_data);
    fetch_t f;
    pc_write        = pw;
    pc_src          = ps;
    alu_result      = alu;
    ir_write        = iw;
    next_inst_write = niw;
    mem_rvalid      = 1'b0;
    mem_rdata       = 16'hBEEF;
    if (mem_read_req === 1'b1) begin
      if (wcnt >= mem_lat) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_img[mem_addr];
        wcnt       = 0;
        if (rand_lat) mem_lat = $urandom_range(0, 2);
      end else begin
        wcnt++;
      end
    end else if (spur) begin
      mem_rvalid = 1'b1;
      mem_rdata  = spur_data;
    end

    if (q.size() == 0) begin
      if (iw) begin
        q.push_back('{addr: m_pc, to_nir: 1'b0});
        if (niw) q.push_back('{addr: m_pc + 16'd1, to_nir: 1'b1});
      end
      if (pw) m_pc = ps ? m_pc + 16'd1 : alu;
    end else begin
      if (pw || iw) m_err = 1'b1;
      if (mem_rvalid) begin
        f = q.pop_front();
        if (f.to_nir) m_nir = mem_img[f.addr];
        else          m_ir  = mem_img[f.addr];
      end
    end

    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles && q.size() != 0; i++) idle_step();
    check("wait_idle_timeout", q.size(), 0);
  endtask

  // Asynchronous reset asserted between clock edges, checked while still low.
  task automatic apply_reset();
    #2;
    rst_n           = 1'b0;
    pc_write        = 1'b0;
    pc_src          = 1'b0;
    ir_write        = 1'b0;
    next_inst_write = 1'b0;
    mem_rvalid      = 1'b0;
    wcnt            = 0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        iw, niw, pw, ps, spur;
    logic [15:0] alu;

    for (int a = 0; a < 65536; a++) mem_img[a] = 16'($urandom);
    mem_img[16'h0000] = 16'h1234;
    mem_img[16'h0010] = 16'h1AAA;
    mem_img[16'h0011] = 16'h00FF;

    vecs[0] = '{pw: 1'b1, ps: 1'b0, alu: 16'h0010, niw: 1'b0, exp_pc: 16'h0010};
    vecs[1] = '{pw: 1'b1, ps: 1'b1, alu: 16'h3333, niw: 1'b0, exp_pc: 16'h0011};
    vecs[2] = '{pw: 1'b0, ps: 1'b0, alu: 16'h7777, niw: 1'b1, exp_pc: 16'h0011};
    vecs[3] = '{pw: 1'b1, ps: 1'b0, alu: 16'hFFFE, niw: 1'b0, exp_pc: 16'hFFFE};
    vecs[4] = '{pw: 1'b1, ps: 1'b1, alu: 16'h0000, niw: 1'b1, exp_pc: 16'hFFFF};
    vecs[5] = '{pw: 1'b1, ps: 1'b1, alu: 16'h1111, niw: 1'b0, exp_pc: 16'h0000};
    vecs[6] = '{pw: 1'b0, ps: 1'b1, alu: 16'h2222, niw: 1'b1, exp_pc: 16'h0000};
    vecs[7] = '{pw: 1'b1, ps: 1'b0, alu: 16'h0005, niw: 1'b0, exp_pc: 16'h0005};

    rst_n           = 1'b0;
    pc_write        = 1'b0;
    pc_src          = 1'b0;
    ir_write        = 1'b0;
    next_inst_write = 1'b0;
    alu_result      = 16'h0000;
    mem_rdata       = 16'h0000;
    mem_rvalid      = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // One-word fetch, memory answers one cycle after the request
    mem_lat = 1;
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);
    check("t1_addr", mem_addr, 16'h0000);
    check("t1_busy1", fetch_busy, 1'b1);
    idle_step();
    check("t1_busy2", fetch_busy, 1'b1);
    idle_step();
    check("t1_ir", ir, 16'h1234);
    check("t1_opcode", opcode, 4'h1);
    check("t1_busy3", fetch_busy, 1'b0);

    // PC update table, IDLE only; next_inst_write alone never starts a fetch
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].pw, vecs[i].ps, vecs[i].alu, 1'b0, vecs[i].niw, 1'b0, 16'h0000);
      check($sformatf("tbl_pc[%0d]", i), pc, vecs[i].exp_pc);
      check($sformatf("tbl_busy[%0d]", i), fetch_busy, 1'b0);
    end

    // Simultaneous ir_write and pc_write at pc=0x0005
    mem_lat = 0;
    step(1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);
    check("t6_addr", mem_addr, 16'h0005);
    check("t6_pc", pc, 16'h0006);
    wait_idle(10);

    // Two-word fetch at 0x0010
    step(1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000);
    check("t2_addr_ir", mem_addr, 16'h0010);
    idle_step();
    check("t2_addr_nir", mem_addr, 16'h0011);
    check("t2_ir", ir, 16'h1AAA);
    check("t2_busy_mid", fetch_busy, 1'b1);
    idle_step();
    check("t2_nir", next_inst, 16'h00FF);
    check("t2_busy_end", fetch_busy, 1'b0);

    // Two-word fetch at 0xFFFF wraps the NIR address, then PC wraps
    step(1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000);
    check("t3_addr_ir", mem_addr, 16'hFFFF);
    idle_step();
    check("t3_addr_nir", mem_addr, 16'h0000);
    wait_idle(10);
    step(1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    check("t3_pc_wrap", pc, 16'h0000);

    // pc_write during REQ_IR is ignored and flags seq_err; repeated in IDLE it applies
    mem_lat = 2;
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 16'h0200, 1'b0, 1'b0, 1'b0, 16'h0000);
    check("t4_pc_held", pc, 16'h0000);
    check("t4_seq_err", seq_err, 1'b1);
    wait_idle(10);
    step(1'b1, 1'b0, 16'h0200, 1'b0, 1'b0, 1'b0, 16'h0000);
    check("t4_pc_idle", pc, 16'h0200);
    check("t4_seq_err_sticky", seq_err, 1'b1);

    // Reset in the middle of REQ_NIR; a late rvalid must be ignored
    mem_lat = 0;
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000);
    idle_step();
    mem_lat = 5;
    idle_step();
    check("t5_in_nir", mem_addr, 16'h0201);
    apply_reset();
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hDEAD);
    check("t5_ir", ir, 16'h0000);
    check("t5_nir", next_inst, 16'h0000);
    check("t5_pc", pc, 16'h0000);
    check("t5_busy", fetch_busy, 1'b0);
    check("t5_seq_err", seq_err, 1'b0);

    // Randomized run against the model
    rand_lat = 1'b1;
    mem_lat  = $urandom_range(0, 2);
    for (int c = 0; c < 1500; c++) begin
      if (q.size() == 0) begin
        iw  = ($urandom_range(0, 2) == 0);
        pw  = ($urandom_range(0, 2) == 0);
      end else begin
        iw  = ($urandom_range(0, 39) == 0);
        pw  = ($urandom_range(0, 39) == 0);
      end
      niw  = 1'($urandom);
      ps   = 1'($urandom);
      alu  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      spur = ($urandom_range(0, 3) == 0);
      step(pw, ps, alu, iw, niw, spur, 16'($urandom));
      if ($urandom_range(0, 299) == 0) apply_reset();
    end
    wait_idle(20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Front-end stage of the Schwap multicycle CPU. Sits between unified memory and the control FSM.
- Owns the PC, the instruction register (IR) and the next-instruction register (NIR, which holds the immediate of two-word instructions).
- Performs handshaked memory reads under the control FSM's pc_write / pc_src / ir_write / next_inst_write strobes.
- Supplies opcode[3:0] back to the control FSM.

Parameters:
- DATA_W, 16, instruction/data word width
- ADDR_W, 16, PC and memory address width
- RESET_PC, 0, PC value after reset

Ports:
- clk  input  1  system clock; all state updates on posedge
- rst_n  input  1  asynchronous active-low reset
- pc_write  input  1  PC update strobe from control FSM
- pc_src  input  1  1: PC <= PC+1; 0: PC <= alu_result
- ir_write  input  1  start instruction fetch at PC
- next_inst_write  input  1  sampled with ir_write; 1 = also fetch word at PC+1 into NIR
- alu_result  input  ADDR_W  branch/jump target
- mem_rdata  input  DATA_W  memory read data
- mem_rvalid  input  1  mem_rdata valid this cycle
- mem_addr  output  ADDR_W  read address (registered)
- mem_read_req  output  1  read request, held until mem_rvalid
- pc  output  ADDR_W  current PC
- ir  output  DATA_W  instruction register
- next_inst  output  DATA_W  NIR
- opcode  output  4  ir[15:12]
- fetch_busy  output  1  fetch in progress; control FSM must hold its state
- seq_err  output  1  sticky: illegal strobe seen while busy

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC; ir, next_inst, mem_addr = 0; mem_read_req, fetch_busy, seq_err = 0; FSM=IDLE. A fetch in flight is aborted; any later mem_rvalid for it is ignored (FSM is IDLE).
- FSM states: IDLE, REQ_IR, REQ_NIR.
- IDLE + ir_write=1:
  - Next cycle: REQ_IR, mem_addr=pc, mem_read_req=1, fetch_busy=1.
  - Latch two_word flag = next_inst_write.
- REQ_IR + mem_rvalid=1:
  - ir <= mem_rdata.
  - If two_word: -> REQ_NIR, mem_addr <= pc+1 (mod 2^ADDR_W), mem_read_req stays 1.
  - Else: -> IDLE, mem_read_req=0, fetch_busy=0.
- REQ_NIR + mem_rvalid=1: next_inst <= mem_rdata; -> IDLE; mem_read_req=0, fetch_busy=0.
- Latency with zero-wait memory (mem_rvalid in the first request cycle):
  - One-word fetch: ir valid and fetch_busy low 2 cycles after the ir_write edge.
  - Two-word fetch: 3 cycles.
- mem_rvalid in IDLE: ignored. mem_rvalid while mem_read_req is held: no timeout; wait indefinitely.
- PC update, IDLE only:
  - pc_write=1, pc_src=1: pc <= pc+1.
  - pc_write=1, pc_src=0: pc <= alu_result.
  - Wraps 0xFFFF+1 -> 0x0000; same wrap applies to the NIR address.
- Simultaneous pc_write and ir_write in IDLE: fetch uses the old pc; PC updates in the same edge.
- pc_write or ir_write while fetch_busy=1: ignored (PC, IR and fetch unchanged); seq_err <= 1. seq_err clears only on reset.
- next_inst_write without ir_write: ignored, no error.
- opcode is combinational from the ir register; stable except on the IR load edge.
- No combinational path from any input to mem_addr or mem_read_req.

Test Plan:
- Reset, then ir_write with mem returning 0x1234 one cycle after request -> mem_addr=0x0000, ir=0x1234, opcode=0x1, fetch_busy low 3 cycles after the strobe.
- Two-word fetch at pc=0x0010, mem returns 0x1AAA then 0x00FF -> mem_addr 0x0010 then 0x0011, ir=0x1AAA, next_inst=0x00FF.
- pc=0xFFFF: two-word fetch -> NIR address 0x0000; then pc_write with pc_src=1 -> pc=0x0000.
- pc_write with pc_src=0, alu_result=0x0200, asserted during REQ_IR -> pc unchanged, seq_err=1. Same strobe repeated in IDLE -> pc=0x0200.
- rst_n low mid-REQ_NIR, then release; late mem_rvalid with data 0xDEAD -> ir, next_inst = 0, pc=RESET_PC, fetch_busy=0.
- ir_write and pc_write(pc_src=1) in the same cycle at pc=0x0005 -> mem_addr=0x0005, pc=0x0006.
